// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush/halt sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage status in, hold/bubble controls out; stats ports exist only with PIPE_CTRL_STATS_EN.
interface pipe_ctrl_if;

    logic [4:0]  ID_src1;
    logic [4:0]  ID_src2;
    logic        ID_src1_used;
    logic        ID_src2_used;
    logic        ID_hlt;
    logic [4:0]  EX_dst_reg;
    logic        EX_wb_we;
    logic        EX_wb_mem_sel;
    logic        EX_branch_taken;
    logic        dmem_req;
    logic        dmem_rdy;
    logic        WB_hlt;

    logic        IF_stall;
    logic        IFID_stall;
    logic        IDEX_stall;
    logic        EXMEM_stall;
    logic        IFID_flush;
    logic        IDEX_flush;
    logic        MEMWB_flush;
    logic        halted;
    logic [1:0]  state;
`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stat_stall_cycles;
    logic [31:0] stat_flush_count;
    logic [31:0] stat_memwait_cycles;
`endif

    modport master (
        output ID_src1, ID_src2, ID_src1_used, ID_src2_used, ID_hlt,
        output EX_dst_reg, EX_wb_we, EX_wb_mem_sel, EX_branch_taken,
        output dmem_req, dmem_rdy, WB_hlt,
        input  IF_stall, IFID_stall, IDEX_stall, EXMEM_stall,
        input  IFID_flush, IDEX_flush, MEMWB_flush, halted, state
`ifdef PIPE_CTRL_STATS_EN
        , input stat_stall_cycles, stat_flush_count, stat_memwait_cycles
`endif
    );

    modport slave (
        input  ID_src1, ID_src2, ID_src1_used, ID_src2_used, ID_hlt,
        input  EX_dst_reg, EX_wb_we, EX_wb_mem_sel, EX_branch_taken,
        input  dmem_req, dmem_rdy, WB_hlt,
        output IF_stall, IFID_stall, IDEX_stall, EXMEM_stall,
        output IFID_flush, IDEX_flush, MEMWB_flush, halted, state
`ifdef PIPE_CTRL_STATS_EN
        , output stat_stall_cycles, stat_flush_count, stat_memwait_cycles
`endif
    );

endinterface

// File: rtl/pipe_ctrl_stats.sv
// Saturating performance counters for pipe_ctrl; frozen while the core is halted.
module pipe_ctrl_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        memwait_i,
    output logic [31:0] stat_stall_cycles_o,
    output logic [31:0] stat_flush_count_o,
    output logic [31:0] stat_memwait_cycles_o
);

    logic [31:0] stall_q;
    logic [31:0] flush_q;
    logic [31:0] memwait_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q   <= '0;
            flush_q   <= '0;
            memwait_q <= '0;
        end else if (!freeze_i) begin
            if (stall_i && (stall_q != '1))
                stall_q <= stall_q + 32'd1;
            if (flush_i && (flush_q != '1))
                flush_q <= flush_q + 32'd1;
            if (memwait_i && (memwait_q != '1))
                memwait_q <= memwait_q + 32'd1;
        end
    end

    assign stat_stall_cycles_o   = stall_q;
    assign stat_flush_count_o    = flush_q;
    assign stat_memwait_cycles_o = memwait_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/halt sequencer for the 5-stage pipeline.
// Define PIPE_CTRL_STATS_EN to build the pipe_ctrl_stats counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    state_t state_q, state_d;
    logic   halted_q;

    logic lu_src1, lu_src2, load_use, mem_wait, branch_ev;
    logic if_stall, ifid_stall, idex_stall, exmem_stall;
    logic ifid_flush, idex_flush, memwb_flush;

    assign lu_src1   = bus.ID_src1_used && (bus.ID_src1 == bus.EX_dst_reg);
    assign lu_src2   = bus.ID_src2_used && (bus.ID_src2 == bus.EX_dst_reg);
    assign load_use  = bus.EX_wb_mem_sel && bus.EX_wb_we &&
                       (bus.EX_dst_reg != REG_ZERO) && (lu_src1 || lu_src2);
    assign mem_wait  = bus.dmem_req && !bus.dmem_rdy && (state_q != ST_HALTED);
    assign branch_ev = bus.EX_branch_taken && !mem_wait && (state_q != ST_HALTED);

    always_comb begin
        if_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (rst) begin
            if_stall = 1'b0;
        end else if (state_q == ST_HALTED) begin
            {if_stall, ifid_stall, idex_stall, exmem_stall} = '1;
            {ifid_flush, idex_flush, memwb_flush}           = '1;
        end else if (mem_wait) begin
            {if_stall, ifid_stall, idex_stall, exmem_stall} = '1;
            memwb_flush = 1'b1;
        end else begin
            if (branch_ev) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                if_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
            // A redirect in DRAIN must be able to load the PC, so the drain hold yields to it.
            if ((state_q == ST_DRAIN) && !branch_ev) begin
                if_stall   = 1'b1;
                ifid_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!mem_wait) begin
            case (state_q)
                ST_RUN: begin
                    if (branch_ev)
                        state_d = ST_RUN;
                    else if (bus.WB_hlt)
                        state_d = ST_HALTED;
                    else if (!load_use && bus.ID_hlt)
                        state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (branch_ev)
                        state_d = ST_RUN;
                    else if (bus.WB_hlt)
                        state_d = ST_HALTED;
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALTED);
        end
    end

    assign bus.IF_stall    = if_stall;
    assign bus.IFID_stall  = ifid_stall;
    assign bus.IDEX_stall  = idex_stall;
    assign bus.EXMEM_stall = exmem_stall;
    assign bus.IFID_flush  = ifid_flush;
    assign bus.IDEX_flush  = idex_flush;
    assign bus.MEMWB_flush = memwb_flush;
    assign bus.halted      = halted_q;
    assign bus.state       = state_q;

`ifdef PIPE_CTRL_STATS_EN
    pipe_ctrl_stats u_stats (
        .clk                   (clk),
        .rst                   (rst),
        .freeze_i              (halted_q),
        .stall_i               (if_stall),
        .flush_i               (branch_ev),
        .memwait_i             (mem_wait),
        .stat_stall_cycles_o   (bus.stat_stall_cycles),
        .stat_flush_count_o    (bus.stat_flush_count),
        .stat_memwait_cycles_o (bus.stat_memwait_cycles)
    );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized cycles against a reference model.
module tb_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_ctrl_if bus();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vec_n  = 0;
    int miss_n = 0;

    // Reference mode: 0 running, 1 draining after a decoded halt, 2 halted.
    int m_mode = 0;
`ifdef PIPE_CTRL_STATS_EN
    longint unsigned m_stall = 0, m_flush = 0, m_mw = 0;
`endif

    function automatic logic m_load_use();
        logic hit1, hit2;
        hit1 = bus.ID_src1_used && (bus.ID_src1 == bus.EX_dst_reg);
        hit2 = bus.ID_src2_used && (bus.ID_src2 == bus.EX_dst_reg);
        return bus.EX_wb_mem_sel && bus.EX_wb_we && (bus.EX_dst_reg != 5'd0) && (hit1 || hit2);
    endfunction

    function automatic logic m_wait();
        return bus.dmem_req && !bus.dmem_rdy && (m_mode != 2);
    endfunction

    // Expected {IF_stall, IFID_stall, IDEX_stall, EXMEM_stall, IFID_flush, IDEX_flush, MEMWB_flush}.
    function automatic logic [6:0] m_ctrl();
        logic [6:0] r;
        if (m_mode == 2) return 7'b1111111;
        if (m_wait())    return 7'b1111001;
        r = 7'b0;
        if (bus.EX_branch_taken)  r = 7'b0000110;
        else if (m_load_use())    r = 7'b1100010;
        if (m_mode == 1 && !bus.EX_branch_taken) r = r | 7'b1000100;
        return r;
    endfunction

    function automatic int m_next();
        if (m_mode == 2)         return 2;
        if (m_wait())            return m_mode;
        if (bus.EX_branch_taken) return 0;
        if (bus.WB_hlt)          return 2;
        if (m_mode == 0 && bus.ID_hlt && !m_load_use()) return 1;
        return m_mode;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
`ifdef PIPE_CTRL_STATS_EN
            m_stall <= 0; m_flush <= 0; m_mw <= 0;
`endif
        end else begin
`ifdef PIPE_CTRL_STATS_EN
            if (m_mode != 2) begin
                if (m_ctrl()     [6]) m_stall <= m_stall + 1;
                if (bus.EX_branch_taken && !m_wait()) m_flush <= m_flush + 1;
                if (m_wait()) m_mw <= m_mw + 1;
            end
`endif
            m_mode <= m_next();
        end
    end

    function automatic logic [6:0] dut_ctrl();
        return {bus.IF_stall, bus.IFID_stall, bus.IDEX_stall, bus.EXMEM_stall,
                bus.IFID_flush, bus.IDEX_flush, bus.MEMWB_flush};
    endfunction

    task automatic idle();
        bus.ID_src1 = 5'd0; bus.ID_src2 = 5'd0;
        bus.ID_src1_used = 1'b0; bus.ID_src2_used = 1'b0; bus.ID_hlt = 1'b0;
        bus.EX_dst_reg = 5'd0; bus.EX_wb_we = 1'b0; bus.EX_wb_mem_sel = 1'b0;
        bus.EX_branch_taken = 1'b0; bus.dmem_req = 1'b0; bus.dmem_rdy = 1'b0;
        bus.WB_hlt = 1'b0;
    endtask

    task automatic rand_inputs();
        bus.ID_src1 = 5'($urandom_range(0, 7));
        bus.ID_src2 = 5'($urandom_range(0, 7));
        bus.ID_src1_used = 1'($urandom_range(0, 1));
        bus.ID_src2_used = 1'($urandom_range(0, 1));
        bus.ID_hlt = ($urandom_range(0, 9) == 0);
        bus.EX_dst_reg = 5'($urandom_range(0, 7));
        bus.EX_wb_we = 1'($urandom_range(0, 1));
        bus.EX_wb_mem_sel = 1'($urandom_range(0, 1));
        bus.EX_branch_taken = ($urandom_range(0, 5) == 0);
        bus.dmem_req = ($urandom_range(0, 2) == 0);
        bus.dmem_rdy = 1'($urandom_range(0, 1));
        bus.WB_hlt = ($urandom_range(0, 15) == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_load(input logic [4:0] dst);
        bus.EX_wb_mem_sel = 1'b1; bus.EX_wb_we = 1'b1; bus.EX_dst_reg = dst;
    endtask

    task automatic test_reset();
        idle();
        bus.dmem_req = 1'b1; bus.ID_hlt = 1'b1; bus.EX_branch_taken = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        settle();
        vec_n++; if (dut_ctrl() !== 7'b0) begin miss_n++; $display("FAIL rst_ctrl: got %b want %b", dut_ctrl(), 7'b0); end
        vec_n++; if (bus.state !== 2'b00) begin miss_n++; $display("FAIL rst_state: got %b want 00", bus.state); end
        vec_n++; if (bus.halted !== 1'b0) begin miss_n++; $display("FAIL rst_halted: got %b want 0", bus.halted); end
        tick();
        rst = 1'b0;
        idle();
        settle();
        vec_n++; if (dut_ctrl() !== 7'b0) begin miss_n++; $display("FAIL post_rst_ctrl: got %b want %b", dut_ctrl(), 7'b0); end
    endtask

    task automatic test_load_use();
        tick(); idle();
        set_load(5'd5); bus.ID_src2 = 5'd5; bus.ID_src2_used = 1'b1;
        bus.ID_src1 = 5'd3; bus.ID_src1_used = 1'b1;
        settle();
        vec_n++; if (dut_ctrl() !== 7'b1100010) begin miss_n++; $display("FAIL lu_src2: got %b want %b", dut_ctrl(), 7'b1100010); end
        tick(); idle();
        bus.ID_src2 = 5'd5; bus.ID_src2_used = 1'b1;
        settle();
        vec_n++; if (dut_ctrl() !== 7'b0) begin miss_n++; $display("FAIL lu_release: got %b want %b", dut_ctrl(), 7'b0); end
        tick(); idle();
        set_load(5'd0); bus.ID_src2 = 5'd0; bus.ID_src2_used = 1'b1;
        settle();
        vec_n++; if (dut_ctrl() !== 7'b0) begin miss_n++; $display("FAIL lu_r0: got %b want %b", dut_ctrl(), 7'b0); end
        tick(); idle();
        set_load(5'd9); bus.ID_src1 = 5'd9; bus.ID_src1_used = 1'b1;
        settle();
        vec_n++; if (dut_ctrl() !== 7'b1100010) begin miss_n++; $display("FAIL lu_src1: got %b want %b", dut_ctrl(), 7'b1100010); end
        tick(); idle();
        set_load(5'd9); bus.ID_src1 = 5'd9; bus.ID_src1_used = 1'b0;
        settle();
        vec_n++; if (dut_ctrl() !== 7'b0) begin miss_n++; $display("FAIL lu_unused: got %b want %b", dut_ctrl(), 7'b0); end
    endtask

    task automatic test_branch_over_load_use();
        tick(); idle();
        set_load(5'd7); bus.ID_src1 = 5'd7; bus.ID_src1_used = 1'b1;
        bus.EX_branch_taken = 1'b1;
        settle();
        vec_n++; if (dut_ctrl() !== 7'b0000110) begin miss_n++; $display("FAIL br_over_lu: got %b want %b", dut_ctrl(), 7'b0000110); end
        vec_n++; if (bus.state !== 2'b00) begin miss_n++; $display("FAIL br_state: got %b want 00", bus.state); end
    endtask

    task automatic test_mem_wait();
        for (int i = 0; i < 3; i++) begin
            tick(); idle();
            bus.dmem_req = 1'b1;
            bus.EX_branch_taken = (i != 0);
            settle();
            vec_n++; if (dut_ctrl() !== 7'b1111001) begin miss_n++; $display("FAIL mw_hold[%0d]: got %b want %b", i, dut_ctrl(), 7'b1111001); end
        end
        tick(); idle();
        bus.dmem_req = 1'b1; bus.dmem_rdy = 1'b1; bus.EX_branch_taken = 1'b1;
        settle();
        vec_n++; if (dut_ctrl() !== 7'b0000110) begin miss_n++; $display("FAIL mw_rdy: got %b want %b", dut_ctrl(), 7'b0000110); end
        tick(); idle(); settle();
        vec_n++; if (dut_ctrl() !== 7'b0) begin miss_n++; $display("FAIL mw_after: got %b want %b", dut_ctrl(), 7'b0); end
    endtask

    task automatic test_halt();
        tick(); idle(); bus.ID_hlt = 1'b1; settle();
        vec_n++; if (dut_ctrl() !== 7'b0) begin miss_n++; $display("FAIL hlt_dec_ctrl: got %b want %b", dut_ctrl(), 7'b0); end
        for (int i = 0; i < 3; i++) begin
            tick(); idle();
            bus.WB_hlt = (i == 2);
            settle();
            vec_n++; if (bus.state !== 2'b01) begin miss_n++; $display("FAIL drain_state[%0d]: got %b want 01", i, bus.state); end
            vec_n++; if (dut_ctrl() !== 7'b1000100) begin miss_n++; $display("FAIL drain_ctrl[%0d]: got %b want %b", i, dut_ctrl(), 7'b1000100); end
            vec_n++; if (bus.halted !== 1'b0) begin miss_n++; $display("FAIL drain_halted[%0d]: got %b want 0", i, bus.halted); end
        end
        for (int i = 0; i < 12; i++) begin
            tick(); rand_inputs(); settle();
            vec_n++; if (bus.state !== 2'b10) begin miss_n++; $display("FAIL halted_state[%0d]: got %b want 10", i, bus.state); end
            vec_n++; if (bus.halted !== 1'b1) begin miss_n++; $display("FAIL halted_flag[%0d]: got %b want 1", i, bus.halted); end
            vec_n++; if (dut_ctrl() !== 7'b1111111) begin miss_n++; $display("FAIL halted_ctrl[%0d]: got %b want %b", i, dut_ctrl(), 7'b1111111); end
        end
    endtask

    task automatic test_reset_in_halted();
        #1 rst = 1'b1;
        #1;
        vec_n++; if (bus.state !== 2'b00) begin miss_n++; $display("FAIL arst_state: got %b want 00", bus.state); end
        vec_n++; if (bus.halted !== 1'b0) begin miss_n++; $display("FAIL arst_halted: got %b want 0", bus.halted); end
        vec_n++; if (dut_ctrl() !== 7'b0) begin miss_n++; $display("FAIL arst_ctrl: got %b want %b", dut_ctrl(), 7'b0); end
`ifdef PIPE_CTRL_STATS_EN
        vec_n++; if (bus.stat_stall_cycles !== 32'd0) begin miss_n++; $display("FAIL arst_stat_stall: got %0d want 0", bus.stat_stall_cycles); end
        vec_n++; if (bus.stat_flush_count !== 32'd0) begin miss_n++; $display("FAIL arst_stat_flush: got %0d want 0", bus.stat_flush_count); end
        vec_n++; if (bus.stat_memwait_cycles !== 32'd0) begin miss_n++; $display("FAIL arst_stat_mw: got %0d want 0", bus.stat_memwait_cycles); end
`endif
        tick(); rst = 1'b0; idle(); settle();
        vec_n++; if (bus.state !== 2'b00) begin miss_n++; $display("FAIL post_arst_state: got %b want 00", bus.state); end
    endtask

    task automatic test_wrong_path_halt();
        tick(); idle(); bus.ID_hlt = 1'b1; settle();
        tick(); idle(); bus.EX_branch_taken = 1'b1; settle();
        vec_n++; if (bus.state !== 2'b01) begin miss_n++; $display("FAIL wp_drain: got %b want 01", bus.state); end
        vec_n++; if (dut_ctrl() !== 7'b0000110) begin miss_n++; $display("FAIL wp_branch_ctrl: got %b want %b", dut_ctrl(), 7'b0000110); end
        for (int i = 0; i < 4; i++) begin
            tick(); idle(); settle();
            vec_n++; if (bus.state !== 2'b00) begin miss_n++; $display("FAIL wp_state[%0d]: got %b want 00", i, bus.state); end
            vec_n++; if (bus.halted !== 1'b0) begin miss_n++; $display("FAIL wp_halted[%0d]: got %b want 0", i, bus.halted); end
            vec_n++; if (dut_ctrl() !== 7'b0) begin miss_n++; $display("FAIL wp_ctrl[%0d]: got %b want %b", i, dut_ctrl(), 7'b0); end
        end
    endtask

    task automatic test_random();
        logic [6:0] exp;
        for (int i = 0; i < 600; i++) begin
            tick();
            rst = 1'b0;
            rand_inputs();
            settle();
            exp = m_ctrl();
            vec_n++; if (dut_ctrl() !== exp) begin miss_n++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", i, dut_ctrl(), exp); end
            vec_n++; if (bus.state !== 2'(m_mode)) begin miss_n++; $display("FAIL rnd_state[%0d]: got %b want %0d", i, bus.state, m_mode); end
            vec_n++; if (bus.halted !== (m_mode == 2)) begin miss_n++; $display("FAIL rnd_halted[%0d]: got %b want %b", i, bus.halted, (m_mode == 2)); end
`ifdef PIPE_CTRL_STATS_EN
            vec_n++; if (bus.stat_stall_cycles !== m_stall[31:0]) begin miss_n++; $display("FAIL rnd_stat_stall[%0d]: got %0d want %0d", i, bus.stat_stall_cycles, m_stall); end
            vec_n++; if (bus.stat_flush_count !== m_flush[31:0]) begin miss_n++; $display("FAIL rnd_stat_flush[%0d]: got %0d want %0d", i, bus.stat_flush_count, m_flush); end
            vec_n++; if (bus.stat_memwait_cycles !== m_mw[31:0]) begin miss_n++; $display("FAIL rnd_stat_mw[%0d]: got %0d want %0d", i, bus.stat_memwait_cycles, m_mw); end
`endif
            if (m_mode == 2 && $urandom_range(0, 3) == 0) begin
                rst = 1'b1;
                #1;
                vec_n++; if (dut_ctrl() !== 7'b0) begin miss_n++; $display("FAIL rnd_rst_ctrl[%0d]: got %b want %b", i, dut_ctrl(), 7'b0); end
                vec_n++; if (bus.state !== 2'b00) begin miss_n++; $display("FAIL rnd_rst_state[%0d]: got %b want 00", i, bus.state); end
            end
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_mem_wait();
        test_halt();
        test_reset_in_halted();
        test_wrong_path_halt();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush/halt sequencer for the 5-stage CPU pipeline. Watches decode, execute, memory and writeback stage status and drives hold and bubble controls into the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken-branch redirects, data-memory wait states and halt drain, and owns the sticky halted state of the core.

## Interface
- No parameters.
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ID_src1, ID_src2  in  5 each  decode-stage source register numbers
- ID_src1_used, ID_src2_used  in  1 each  source is actually read by the decoded instruction
- ID_hlt  in  1  halt instruction in decode
- EX_dst_reg  in  5  execute-stage destination register
- EX_wb_we  in  1  execute-stage instruction writes the register file
- EX_wb_mem_sel  in  1  execute-stage instruction is a load
- EX_branch_taken  in  1  execute-stage branch/jump redirects the PC this cycle
- dmem_req  in  1  memory-stage access in progress
- dmem_rdy  in  1  data memory completes the access this cycle
- WB_hlt  in  1  halt instruction has reached writeback
- IF_stall  out  1  hold PC
- IFID_stall, IDEX_stall, EXMEM_stall  out  1 each  hold the register contents
- IFID_flush, IDEX_flush, MEMWB_flush  out  1 each  load a bubble (all controls zero)
- halted  out  1  core halted, sticky until reset
- state  out  2  current FSM state (debug)

## Operation
- FSM states: RUN (00), DRAIN (01), HALTED (10). Encoding 11 is unused and recovers to RUN.
- Event priority, highest first: HALTED > mem-wait > branch > load-use > halt-in-decode.
- Mem-wait (dmem_req && !dmem_rdy, any state except HALTED):
  - assert IF_stall, IFID_stall, IDEX_stall, EXMEM_stall and MEMWB_flush;
  - suppress all other events this cycle;
  - FSM state does not change.
- Branch (EX_branch_taken): assert IFID_flush and IDEX_flush. In DRAIN, the FSM goes to RUN, because the halt was on the wrong path.
- Load-use: EX_wb_mem_sel && EX_wb_we && EX_dst_reg != 0 && ((ID_src1_used && ID_src1 == EX_dst_reg) || (ID_src2_used && ID_src2 == EX_dst_reg)).
  - Response: IF_stall, IFID_stall and IDEX_flush for exactly that cycle.
  - Register 0 never matches.
- Halt-in-decode (RUN, ID_hlt, no higher event): go to DRAIN.
- DRAIN: assert IF_stall and IFID_flush every cycle so only bubbles follow the halt. On WB_hlt, go to HALTED.
- HALTED: assert all stall outputs, IFID_flush, IDEX_flush and MEMWB_flush; halted=1. Only rst exits this state.
- WB_hlt seen in RUN (decode event missed) still goes to HALTED.

## Timing
- All stall/flush outputs are combinational from the current state and this cycle's inputs, so the response acts in the same cycle as the event.
- state and halted are registered and change on the posedge of clk.
- Reset: state=RUN, halted=0. While rst is high, every stall/flush output is forced to 0.
- Reset asserted mid-DRAIN or in HALTED returns to RUN asynchronously.
- Load-use costs exactly 1 bubble.
- Branch costs 2 flushed slots.
- Mem-wait costs N cycles for an N-cycle wait; the cycle with dmem_rdy=1 is not stalled.
- DRAIN to HALTED: the transition takes effect on the edge after WB_hlt=1, so halted rises 1 cycle after WB_hlt.

## Configuration
- PIPE_CTRL_STATS_EN defined: add outputs stat_stall_cycles [31:0], stat_flush_count [31:0] and stat_memwait_cycles [31:0].
  - All three reset to 0, saturate at 0xFFFFFFFF and freeze while halted.
  - stat_stall_cycles counts cycles with IF_stall=1 and halted=0.
  - stat_flush_count counts branch events.
  - stat_memwait_cycles counts mem-wait cycles.
- PIPE_CTRL_STATS_EN undefined: these ports and the counters do not exist. Control behaviour is identical either way.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (ST_RUN, ST_DRAIN, ST_HALTED);
  - the REG_ZERO constant (5'd0).
- One sub-module, pipe_ctrl_stats, holds the three saturating counters. It is instantiated only under PIPE_CTRL_STATS_EN.
- The hazard compare and the FSM stay in pipe_ctrl.

## Test plan
- Load-use: EX load to r5 with ID_src2=5 and ID_src2_used=1 -> IF_stall=IFID_stall=IDEX_flush=1 for one cycle, then 0. The same with EX_dst_reg=0 -> no stall.
- Branch over load-use: EX_branch_taken=1 together with a load-use match -> IFID_flush=IDEX_flush=1 and IF_stall=0.
- Mem-wait: dmem_req=1 with dmem_rdy=0 for 3 cycles, then 1 -> 3 cycles of all holds plus MEMWB_flush; 0 on the rdy cycle. A branch asserted during the wait is ignored until the wait ends.
- Halt: ID_hlt for 1 cycle, WB_hlt 3 cycles later -> state 01 for 3 cycles, then 10; halted=1 and stays high for 10+ cycles.
- Wrong-path halt: ID_hlt, then EX_branch_taken the next cycle -> state returns to 00 and halted stays 0.
- Reset in HALTED: pulse rst asynchronously -> state=00 and halted=0 immediately. With PIPE_CTRL_STATS_EN defined, all counters also read 0.
